// File: rtl/cpu_seq_ctrl_pkg.sv
// Shared definitions for the bit-serial datapath sequencer: opcodes, ALU
// function encodings, FSM states and opcode classification helpers.
package cpu_seq_ctrl_pkg;

    localparam int DEF_WIDTH = 8;

    typedef logic [3:0] opcode_t;

    localparam opcode_t OP_NOP  = 4'h0;
    localparam opcode_t OP_ADD  = 4'h1;
    localparam opcode_t OP_SUB  = 4'h2;
    localparam opcode_t OP_AND  = 4'h3;
    localparam opcode_t OP_OR   = 4'h4;
    localparam opcode_t OP_XOR  = 4'h5;
    localparam opcode_t OP_PASS = 4'h6;
    localparam opcode_t OP_SHL  = 4'h7;
    localparam opcode_t OP_HALT = 4'hF;

    // Serial ALU function select; ALU_NONE is driven whenever no ALU op is in flight.
    localparam logic [2:0] ALU_NONE = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;
    localparam logic [2:0] ALU_AND  = 3'd3;
    localparam logic [2:0] ALU_OR   = 3'd4;
    localparam logic [2:0] ALU_XOR  = 3'd5;
    localparam logic [2:0] ALU_PASS = 3'd6;
    localparam logic [2:0] ALU_SHL  = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECODE = 3'd1,
        ST_LOAD   = 3'd2,
        ST_SHIFT  = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } seq_state_t;

    function automatic logic [2:0] alu_sel_of(input opcode_t op);
        case (op)
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            OP_XOR:  return ALU_XOR;
            OP_PASS: return ALU_PASS;
            OP_SHL:  return ALU_SHL;
            default: return ALU_NONE;
        endcase
    endfunction

    function automatic logic is_alu_op(input opcode_t op);
        return alu_sel_of(op) != ALU_NONE;
    endfunction

    // Anything that is neither an ALU op, NOP nor HALT retires as illegal.
    function automatic logic is_illegal_op(input opcode_t op);
        return !is_alu_op(op) && (op != OP_NOP) && (op != OP_HALT);
    endfunction

endpackage

// File: rtl/cpu_seq_ctrl_if.sv
// Instruction handshake between the DIP/push-button front end and the sequencer.
interface cpu_seq_ctrl_if;
    import cpu_seq_ctrl_pkg::*;

    logic    instr_valid;
    opcode_t opcode;
    logic    instr_ready;

    modport master (output instr_valid, output opcode, input instr_ready);
    modport slave  (input instr_valid, input opcode, output instr_ready);
endinterface

// File: rtl/cpu_seq_ctrl_bit_counter.sv
// Serial bit counter: cleared before each op, advanced once per shift cycle,
// flags the last bit and wraps to zero only on the step taken from it.
module cpu_seq_ctrl_bit_counter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             tc
);

    assign tc = (count == CNT_W'(WIDTH - 1));

    // Count register: hold unless enabled, wrap at terminal count.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (en) begin
            count <= tc ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/cpu_seq_ctrl.sv
// Sequencer for the bit-serial datapath: takes one decoded instruction at a
// time and drives operand load, WIDTH shift cycles and writeback.
//
//  state  | meaning
//  IDLE   | waiting for an instruction, instr_ready=1
//  DECODE | classify latched opcode; NOP/illegal/HALT retire here
//  LOAD   | parallel-load operand, preset carry, clear bit counter
//  SHIFT  | WIDTH serial shift cycles, bit_idx 0..WIDTH-1
//  WB     | commit result to accumulator, retire
//  HALT   | frozen until reset
module cpu_seq_ctrl
    import cpu_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    cpu_seq_ctrl_if.slave    bus,
    output logic             busy,
    output logic             op_load,
    output logic             shift_en,
    output logic [CNT_W-1:0] bit_idx,
    output logic             last_bit,
    output logic             carry_init,
    output logic             inv_b,
    output logic [2:0]       alu_sel,
    output logic             acc_we,
    output logic             done,
    output logic             illegal,
    output logic             halted,
    output logic             overrun
);

    seq_state_t       state, state_nxt;
    opcode_t          opcode_q;
    logic [CNT_W-1:0] cnt;
    logic             cnt_tc;
    logic             accept;

    assign accept = bus.instr_valid && (state == ST_IDLE);

    cpu_seq_ctrl_bit_counter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_bit_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (state == ST_LOAD),
        .en    (state == ST_SHIFT),
        .count (cnt),
        .tc    (cnt_tc)
    );

    // State register, opcode latch and sticky overrun flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            opcode_q <= OP_NOP;
            overrun  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                opcode_q <= bus.opcode;
            end
            if (bus.instr_valid && (state != ST_IDLE)) begin
                overrun <= 1'b1;
            end
        end
    end

    // Next-state logic and Moore-style control strobes.
    always_comb begin
        state_nxt       = state;
        bus.instr_ready = 1'b0;
        busy            = 1'b0;
        op_load         = 1'b0;
        shift_en        = 1'b0;
        bit_idx         = '0;
        last_bit        = 1'b0;
        carry_init      = 1'b0;
        inv_b           = 1'b0;
        alu_sel         = ALU_NONE;
        acc_we          = 1'b0;
        done            = 1'b0;
        illegal         = 1'b0;
        halted          = 1'b0;

        // Function controls are held steady for the whole op, DECODE through WB.
        if (state inside {ST_DECODE, ST_LOAD, ST_SHIFT, ST_WB}) begin
            busy       = 1'b1;
            alu_sel    = alu_sel_of(opcode_q);
            inv_b      = (opcode_q == OP_SUB);
            carry_init = (opcode_q == OP_SUB);
        end

        case (state)
            ST_IDLE: begin
                bus.instr_ready = 1'b1;
                if (bus.instr_valid) begin
                    state_nxt = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (is_alu_op(opcode_q)) begin
                    state_nxt = ST_LOAD;
                end else if (opcode_q == OP_HALT) begin
                    done      = 1'b1;
                    state_nxt = ST_HALT;
                end else begin
                    done      = 1'b1;
                    illegal   = is_illegal_op(opcode_q);
                    state_nxt = ST_IDLE;
                end
            end
            ST_LOAD: begin
                op_load   = 1'b1;
                state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                shift_en = 1'b1;
                bit_idx  = cnt;
                last_bit = cnt_tc;
                if (cnt_tc) begin
                    state_nxt = ST_WB;
                end
            end
            ST_WB: begin
                acc_we    = 1'b1;
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Bench for cpu_seq_ctrl: directed scenarios followed by random traffic, every
// cycle compared against an instruction-timeline reference model.
module tb_cpu_seq_ctrl;
    import cpu_seq_ctrl_pkg::*;

    localparam int W  = 8;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          busy, op_load, shift_en, last_bit, carry_init, inv_b;
    logic          acc_we, done, illegal, halted, overrun;
    logic [CW-1:0] bit_idx;
    logic [2:0]    alu_sel;

    cpu_seq_ctrl_if bus ();

    cpu_seq_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.slave),
        .busy       (busy),
        .op_load    (op_load),
        .shift_en   (shift_en),
        .bit_idx    (bit_idx),
        .last_bit   (last_bit),
        .carry_init (carry_init),
        .inv_b      (inv_b),
        .alu_sel    (alu_sel),
        .acc_we     (acc_we),
        .done       (done),
        .illegal    (illegal),
        .halted     (halted),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: an instruction is a timeline of offsets from its accept cycle.
    int       cyc       = 0;
    bit       inflight  = 0;
    int       t0        = 0;
    bit [3:0] cur_op    = 0;
    bit       halted_m  = 0;
    bit       overrun_m = 0;
    int       n_acc_we  = 0;
    int       n_done    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [2:0] exp_sel(input bit [3:0] op);
        logic [2:0] tbl [0:15];
        tbl = '{ALU_NONE, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_PASS, ALU_SHL,
                ALU_NONE, ALU_NONE, ALU_NONE, ALU_NONE, ALU_NONE, ALU_NONE, ALU_NONE, ALU_NONE};
        return tbl[op];
    endfunction

    // One clock cycle: check this cycle's outputs, then apply inputs for the next edge.
    task automatic cycle(input bit v, input bit [3:0] op, input bit r);
        bit e_rdy, e_busy, e_load, e_shift, e_last, e_cin, e_inv, e_we, e_done, e_ill;
        int e_idx, e_sel, k;
        bit alu, fin;
        @(negedge clk);
        k     = cyc - t0;
        alu   = (cur_op >= 1 && cur_op <= 7);
        e_rdy = !inflight && !halted_m;
        {e_busy, e_load, e_shift, e_last, e_cin, e_inv, e_we, e_done, e_ill} = '0;
        e_idx = 0;
        e_sel = 0;
        if (inflight) begin
            e_busy = 1;
            if (k == 1 && !alu) begin
                e_done = 1;
                e_ill  = (cur_op >= 8 && cur_op <= 14);
            end
            if (alu) begin
                e_sel   = exp_sel(cur_op);
                e_cin   = (cur_op == 2);
                e_inv   = (cur_op == 2);
                e_load  = (k == 2);
                e_shift = (k >= 3 && k <= 2 + W);
                e_idx   = e_shift ? k - 3 : 0;
                e_last  = (k == 2 + W);
                e_we    = (k == 3 + W);
                e_done  = (k == 3 + W);
            end
        end
        chk("instr_ready", bus.instr_ready, e_rdy);
        chk("busy",        busy,        e_busy);
        chk("op_load",     op_load,     e_load);
        chk("shift_en",    shift_en,    e_shift);
        chk("bit_idx",     bit_idx,     e_idx);
        chk("last_bit",    last_bit,    e_last);
        chk("carry_init",  carry_init,  e_cin);
        chk("inv_b",       inv_b,       e_inv);
        chk("alu_sel",     alu_sel,     e_sel);
        chk("acc_we",      acc_we,      e_we);
        chk("done",        done,        e_done);
        chk("illegal",     illegal,     e_ill);
        chk("halted",      halted,      halted_m);
        chk("overrun",     overrun,     overrun_m);
        n_acc_we += int'(acc_we === 1'b1);
        n_done   += int'(done === 1'b1);

        fin = inflight && (alu ? (k == 3 + W) : (k == 1));
        if (r) begin
            inflight  = 0;
            halted_m  = 0;
            overrun_m = 0;
        end else begin
            if (fin) begin
                inflight = 0;
                if (cur_op == 4'hF) halted_m = 1;
            end
            if (v) begin
                if (e_rdy) begin
                    inflight = 1;
                    t0       = cyc;
                    cur_op   = op;
                end else begin
                    overrun_m = 1;
                end
            end
        end
        rst             = r;
        bus.instr_valid = v;
        bus.opcode      = op;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 4'h0, 0);
    endtask

    initial begin
        int acc0, done0;
        bit r, v;
        bit [3:0] op;

        bus.instr_valid = 1'b0;
        bus.opcode      = 4'h0;
        rst             = 1'b1;
        @(posedge clk);
        cycle(0, 4'h0, 1);
        cycle(0, 4'h0, 0);
        idle(1);

        // ADD, SUB, AND, SHL back to back with no gaps beyond the ready cycle.
        cycle(1, 4'h1, 0); idle(12);
        cycle(1, 4'h2, 0); idle(12);
        cycle(1, 4'h3, 0); idle(11);
        cycle(1, 4'h7, 0); idle(12);

        // NOP then an undefined opcode.
        cycle(1, 4'h0, 0); idle(2);
        cycle(1, 4'h9, 0); idle(2);

        // Overrun during ADD: exactly one writeback, done still on schedule.
        acc0 = n_acc_we;
        cycle(1, 4'h1, 0); idle(4);
        cycle(1, 4'h5, 0); idle(5);
        cycle(1, 4'h4, 0); idle(4);
        chk("overrun_acc_we_count", n_acc_we - acc0, 1);

        // Valid coinciding with WB is dropped; the next one is accepted.
        cycle(1, 4'h6, 0); idle(10);
        cycle(1, 4'h1, 0);
        cycle(1, 4'h1, 0); idle(12);

        // HALT then ignored pulses, then reset clears everything.
        done0 = n_done;
        cycle(1, 4'hF, 0); idle(3);
        cycle(1, 4'h1, 0); idle(2);
        cycle(1, 4'h0, 0); idle(3);
        chk("halt_done_count", n_done - done0, 1);
        cycle(0, 4'h0, 1); idle(2);

        // Reset in the middle of SHIFT: no writeback, no retire.
        acc0  = n_acc_we;
        done0 = n_done;
        cycle(1, 4'h1, 0); idle(5);
        cycle(0, 4'h0, 1); idle(12);
        chk("rst_mid_shift_acc_we", n_acc_we - acc0, 0);
        chk("rst_mid_shift_done",   n_done - done0, 0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            r  = halted_m ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 299) == 0);
            v  = ($urandom_range(0, 3) == 0);
            op = ($urandom_range(0, 49) == 0) ? 4'hF : 4'($urandom_range(0, 14));
            cycle(v, op, r);
        end
        idle(W + 6);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
